// File: rtl/tmss_lockout_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tmss_lockout_ctrl
// Description : Boot-lockout controller for the 68k/VDP bus. Holds the VDP in
//               reset (LOCK_n low) until software has written the expected
//               SIG_WORDS x 16-bit signature and then touches the VDP address
//               range. Also overlays an external boot ROM on cartridge space,
//               selected by a one-bit bank register.
// Ports       :
//   MCLK, SRES_N          clock, synchronous active-low reset
//   JAP                   region enable (0 = lockout disabled)
//   AS, UDS, LDS, RW      68k strobes, active-low (RW=1 is a read)
//   VA, VD_i              word address, write data
//   CE0_i, M3, CART       cart select (active-low), mode-3 enable, cart absent
//   rom_data / rom_addr   synchronous boot ROM port (1-cycle latency)
//   VD_o, data_oe, DTACK  read data, read data enable, data acknowledge
//   LOCK_n, CE0_o         VDP reset release, gated cart select
//   state, fault          FSM state (0 locked, 1 unlocked, 2 fault), fault flag
// Revision    : 1.0 - initial release
//==============================================================================
module tmss_lockout_ctrl #(
    parameter int                        SIG_WORDS  = 2,
    parameter logic [16*SIG_WORDS-1:0]   SIG_VALUE  = 32'h53454741,
    parameter logic [22:0]               REG_BASE   = 23'h50a000,
    parameter logic [22:0]               BANK_ADDR  = 23'h50a080,
    parameter int                        ROM_AW     = 10,
    parameter int                        DTACK_WAIT = 0,
    parameter int                        TIMEOUT    = 0
) (
    input  logic              MCLK,
    input  logic              SRES_N,
    input  logic              JAP,
    input  logic              AS,
    input  logic              UDS,
    input  logic              LDS,
    input  logic              RW,
    input  logic [22:0]       VA,
    input  logic [15:0]       VD_i,
    input  logic              CE0_i,
    input  logic              M3,
    input  logic              CART,
    input  logic [15:0]       rom_data,
    output logic [15:0]       VD_o,
    output logic              data_oe,
    output logic              DTACK,
    output logic              LOCK_n,
    output logic              CE0_o,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [1:0]        state,
    output logic              fault
);

    localparam logic [1:0] c_LOCKED   = 2'd0;
    localparam logic [1:0] c_UNLOCKED = 2'd1;
    localparam logic [1:0] c_FAULT    = 2'd2;

    localparam int              c_TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;
    localparam logic [3:0]      c_WAIT     = 4'(DTACK_WAIT);

    // Registered state
    logic [15:0]          r_sig [SIG_WORDS];
    logic                 r_bank;
    logic                 r_match;
    logic                 r_cyc_d;
    logic [1:0]           r_state;
    logic [c_TW-1:0]      r_timer;
    logic [15:0]          r_vd;
    logic                 r_reg_oe;
    logic                 r_rom_oe;
    logic                 r_dtack;
    logic                 r_wait_pend;
    logic [3:0]           r_wait_cnt;

    // Combinational decode
    logic                 w_cyc;
    logic                 w_start;
    logic [SIG_WORDS-1:0] w_reg_sel;
    logic                 w_reg_hit;
    logic                 w_bank_hit;
    logic                 w_hit;
    logic [15:0]          w_reg_rdata;
    logic [16*SIG_WORDS-1:0] w_sig_packed;
    logic                 w_rom_sel;
    logic                 w_rom_rd;
    logic                 w_vdp_unlock;
    logic                 w_timeout;
    logic [1:0]           w_next_state;

    //--------------------------------------------------------------------------
    // Bus cycle detection: actions fire once on the first cycle a strobe is
    // seen, never again while AS is held low.
    //--------------------------------------------------------------------------
    assign w_cyc   = ~AS & (~UDS | ~LDS);
    assign w_start = w_cyc & ~r_cyc_d;

    always_comb begin
        w_reg_sel    = '0;
        w_reg_rdata  = '0;
        w_sig_packed = '0;
        for (int i = 0; i < SIG_WORDS; i++) begin
            w_reg_sel[i] = (VA == REG_BASE + 23'(i));
            // Register selects are one-hot, so OR-ing the hit word is a mux.
            if (w_reg_sel[i]) begin
                w_reg_rdata = r_sig[i];
            end
            // Word 0 sits in the most significant slot of the signature.
            w_sig_packed[16*(SIG_WORDS-1-i) +: 16] = r_sig[i];
        end
    end

    assign w_reg_hit  = |w_reg_sel;
    assign w_bank_hit = (VA == BANK_ADDR);
    assign w_hit      = w_reg_hit | w_bank_hit;

    assign w_rom_sel  = ~CE0_i & ~r_bank & M3 & ~CART;
    assign w_rom_rd   = w_rom_sel & RW & ~AS & ~w_hit;
    assign CE0_o      = CE0_i | w_rom_sel;
    assign rom_addr   = VA[ROM_AW-1:0];

    //--------------------------------------------------------------------------
    // Signature registers with byte-lane writes
    //--------------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (!SRES_N) begin
            for (int i = 0; i < SIG_WORDS; i++) begin
                r_sig[i] <= '0;
            end
        end else if (w_start && !RW) begin
            for (int i = 0; i < SIG_WORDS; i++) begin
                if (w_reg_sel[i]) begin
                    if (!UDS) r_sig[i][15:8] <= VD_i[15:8];
                    if (!LDS) r_sig[i][7:0]  <= VD_i[7:0];
                end
            end
        end
    end

    // Bank register, match flag (one cycle behind the registers), cycle edge
    always_ff @(posedge MCLK) begin
        if (!SRES_N) begin
            r_bank  <= 1'b0;
            r_match <= 1'b0;
            r_cyc_d <= 1'b0;
        end else begin
            if (w_start && !RW && !LDS && w_bank_hit) begin
                r_bank <= VD_i[0];
            end
            r_match <= (w_sig_packed == SIG_VALUE);
            r_cyc_d <= w_cyc;
        end
    end

    //--------------------------------------------------------------------------
    // Read data path and DTACK generation
    //--------------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (!SRES_N) begin
            r_vd        <= '0;
            r_reg_oe    <= 1'b0;
            r_rom_oe    <= 1'b0;
            r_dtack     <= 1'b1;
            r_wait_pend <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_start && w_hit && RW) begin
                r_vd     <= w_bank_hit ? {15'b0, r_bank} : w_reg_rdata;
                r_reg_oe <= 1'b1;
            end else begin
                if (AS) begin
                    r_reg_oe <= 1'b0;
                end
                // ROM data streams through every cycle of a ROM read.
                if (w_rom_rd) begin
                    r_vd <= rom_data;
                end
            end
            r_rom_oe <= w_rom_rd;

            if (AS) begin
                r_dtack     <= 1'b1;
                r_wait_pend <= 1'b0;
            end else if (w_start && w_hit) begin
                if (c_WAIT == 4'd0) begin
                    r_dtack <= 1'b0;
                end else begin
                    r_wait_pend <= 1'b1;
                    r_wait_cnt  <= c_WAIT;
                end
            end else if (r_wait_pend) begin
                if (r_wait_cnt == 4'd1) begin
                    r_dtack     <= 1'b0;
                    r_wait_pend <= 1'b0;
                end else begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end
            end
        end
    end

    assign VD_o    = r_vd;
    assign data_oe = r_reg_oe | r_rom_oe;
    assign DTACK   = r_dtack;

    //--------------------------------------------------------------------------
    // Lockout FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (!SRES_N) begin
            r_state <= c_LOCKED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Unlock timer: counts only while locked and parks at its last value.
    always_ff @(posedge MCLK) begin
        if (!SRES_N) begin
            r_timer <= '0;
        end else if ((TIMEOUT != 0) && (r_state == c_LOCKED) && (r_timer != c_TMO_LAST)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Next-state logic. A qualifying VDP access beats a coincident timeout.
    assign w_vdp_unlock = w_start & (VA[22:20] == 3'h6) & r_match;
    assign w_timeout    = (TIMEOUT != 0) && (r_timer == c_TMO_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LOCKED: begin
                if (w_vdp_unlock) begin
                    w_next_state = c_UNLOCKED;
                end else if (w_timeout) begin
                    w_next_state = c_FAULT;
                end
            end
            c_UNLOCKED: w_next_state = c_UNLOCKED;
            c_FAULT:    w_next_state = c_FAULT;
            default:    w_next_state = c_LOCKED;
        endcase
    end

    // Output logic
    always_comb begin
        state  = r_state;
        LOCK_n = ~JAP | (r_state == c_UNLOCKED);
        fault  = (r_state == c_FAULT);
    end

endmodule
`default_nettype wire

// File: doc/tmss_lockout_ctrl.md
Name: tmss_lockout_ctrl

Overview:
- Parametrised boot-lockout controller for the 68k/VDP bus.
- Holds the VDP reset line (LOCK_n) asserted until software writes a programmable N-word signature, then touches the VDP address range.
- Maps an external boot ROM over cartridge space, selected by a bank register.
- Adds over the previous generation: byte-lane register writes, register readback, configurable DTACK wait states, and an optional unlock timeout that enters a sticky FAULT state.

Parameters:
- SIG_WORDS, 2, number of 16-bit signature registers (1..8).
- SIG_VALUE, 32'h53454741, packed expected signature, 16*SIG_WORDS bits; word i = SIG_VALUE[16*(SIG_WORDS-1-i) +: 16].
- REG_BASE, 23'h50a000, word address of signature register 0; register i sits at REG_BASE+i.
- BANK_ADDR, 23'h50a080, word address of the bank register.
- ROM_AW, 10, boot ROM word-address width.
- DTACK_WAIT, 0, wait cycles before DTACK asserts on a register access (0..15).
- TIMEOUT, 0, MCLK cycles from reset release to FAULT; 0 disables the timeout.

Ports:
- MCLK  in  1  clock.
- SRES_N  in  1  synchronous reset, active-low.
- JAP  in  1  region enable; 0 = lockout disabled.
- AS, UDS, LDS, RW  in  1 each  68k strobes, active-low (RW=1 means read).
- VA  in  23  word address.
- VD_i  in  16  write data.
- CE0_i, M3, CART  in  1 each  cart select (active-low), mode-3 enable, cart-absent flag.
- rom_data  in  16  external synchronous ROM data; 1-cycle latency.
- VD_o  out  16  read data.
- data_oe  out  1  high = VD_o driven.
- DTACK  out  1  active-low.
- LOCK_n  out  1  low = VDP held in reset.
- CE0_o  out  1  gated cart select.
- rom_addr  out  ROM_AW  = VA[ROM_AW-1:0], combinational.
- state  out  2  FSM state.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (SRES_N=0 at an MCLK edge). All of the following take their reset values:
  - state=LOCKED, sig regs=0, bank=0, timer=0, fault=0.
  - VD_o=0, data_oe=0, DTACK=1.
  - LOCK_n=~JAP (combinational).
  - Reset mid-operation aborts any bus cycle and applies the same values.
- Cycle start:
  - cyc = ~AS & (~UDS | ~LDS).
  - A cycle starts on the first MCLK where cyc=1 with cyc=0 the previous cycle.
  - Each action fires once per cycle start; no repeat while AS stays low.
- Signature write (reg hit: VA in [REG_BASE, REG_BASE+SIG_WORDS), RW=0):
  - ~UDS updates bits 15:8; ~LDS updates bits 7:0.
  - match_r is recomputed the following cycle (1-cycle latency).
- Bank write (VA==BANK_ADDR, RW=0, ~LDS): bank <= VD_i[0].
- Register read (reg hit or bank hit, RW=1):
  - VD_o registered at cycle start: sig reg, or {15'b0,bank}.
  - data_oe=1 from that edge until AS=1.
- DTACK for register/bank hits:
  - Goes low DTACK_WAIT cycles after cycle start; DTACK_WAIT=0 means the same edge.
  - Returns high on the cycle after AS=1.
  - Never asserted for any other address.
- ROM select:
  - rom_sel = ~CE0_i & ~bank & M3 & ~CART.
  - CE0_o = CE0_i | rom_sel.
  - When rom_sel & RW & ~AS: VD_o <= rom_data each cycle and data_oe=1.
  - A register/bank hit takes priority over rom_sel.
- FSM (JAP=1):
  - LOCKED -> UNLOCKED: at a cycle start with VA[22:20]==3'h6 and match_r=1.
  - LOCKED -> FAULT: TIMEOUT!=0 and timer reaches TIMEOUT-1 while LOCKED.
  - If the timeout and a qualifying VDP access occur on the same cycle, UNLOCKED wins.
  - A VDP access without a match stays LOCKED.
  - UNLOCKED and FAULT are sticky until reset. Later signature writes do not relock.
- Timer: increments in LOCKED only and saturates at TIMEOUT-1.
- Outputs vs state:
  - LOCK_n = ~JAP | (state==UNLOCKED).
  - fault = (state==FAULT).
  - state encoding: LOCKED=0, UNLOCKED=1, FAULT=2.
- JAP=0:
  - LOCK_n=1.
  - Registers and ROM mapping still operate; FSM still tracks.

Test Plan:
- Unlock: write 16'h5345 to REG_BASE and 16'h4741 to REG_BASE+1, then read VA=23'h600000 -> state=1 and LOCK_n=1 on the edge after the cycle start.
- Wrong signature: write 16'h5346 to REG_BASE, then VDP access -> state stays 0 and LOCK_n=0. Then correct the word and access again -> unlock.
- Byte lanes: write 16'hAB00 with UDS only, then 16'h00CD with LDS only to REG_BASE; read back -> VD_o=16'hABCD, data_oe=1.
- DTACK_WAIT=3: register read -> DTACK low exactly 3 cycles after cycle start; high one cycle after AS=1. Unmapped address -> DTACK stays 1.
- TIMEOUT=100, no writes -> state=2 and fault=1 at cycle 100 after reset release. A matching VDP access afterwards leaves state=2. Pulsing SRES_N low returns state=0.
- ROM map: M3=1, CART=0, bank=0, CE0_i=0, VA=23'h000005 -> CE0_o=1, rom_addr=5, VD_o=rom_data next cycle. After writing bank=1 -> CE0_o=0 and data_oe=0.
